// File: rtl/l1_pkg.sv
// Shared constants and types for the L1 stream buffer fill (write) and read ports.
package l1_pkg;

    localparam int unsigned nstrms       = 64;
    localparam int unsigned nstrms_width = $clog2(nstrms);
    localparam int unsigned nlines       = 4;
    localparam int unsigned nlines_width = $clog2(nlines);
    localparam int unsigned cl_size      = 8;
    localparam int unsigned word_width   = 64;
    localparam int unsigned addr_width   = nstrms_width + nlines_width;
    localparam int unsigned line_width   = cl_size * word_width;

    typedef struct packed {
        logic [nstrms_width-1:0] sid;
        logic [nlines_width-1:0] line;
    } line_addr_t;

    typedef logic [line_width-1:0] cl_data_t;
    typedef logic [nstrms-1:0]     strm_vec_t;

endpackage

// File: rtl/l1_wr_port_if.sv
// Fill-side bus of the L1 write port: L2 line input, BRAM write output, per-stream flags.
interface l1_wr_port_if;
    import l1_pkg::*;

    logic                    i_fill_v;
    logic                    i_fill_r;
    logic [nstrms_width-1:0] i_fill_sid;
    cl_data_t                i_fill_data;
    logic                    i_fill_end;
    logic                    o_wr_v;
    logic                    o_wr_r;
    line_addr_t              o_wr_addr;
    cl_data_t                o_wr_data;
    strm_vec_t               i_line_free;
    strm_vec_t               i_strm_rst;
    strm_vec_t               o_line_v;
    strm_vec_t               o_full;
    strm_vec_t               o_single_v;
    strm_vec_t               o_rst_end;
    logic                    o_err;

    modport slave (
        input  i_fill_v, i_fill_sid, i_fill_data, i_fill_end, o_wr_r, i_line_free, i_strm_rst,
        output i_fill_r, o_wr_v, o_wr_addr, o_wr_data, o_line_v, o_full, o_single_v, o_rst_end,
               o_err
    );

    modport master (
        output i_fill_v, i_fill_sid, i_fill_data, i_fill_end, o_wr_r, i_line_free, i_strm_rst,
        input  i_fill_r, o_wr_v, o_wr_addr, o_wr_data, o_line_v, o_full, o_single_v, o_rst_end,
               o_err
    );

endinterface

// File: rtl/l1_wr_strm_state.sv
// Per-stream write pointer, line occupancy count and end-of-stream flag.
module l1_wr_strm_state
    import l1_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic                    free,
    input  logic                    wr_end,
    input  logic                    strm_rst,
    output logic [nlines_width-1:0] wr_line,
    output logic                    line_v,
    output logic                    full,
    output logic                    single_v,
    output logic                    end_flag,
    output logic                    err
);

    localparam logic [nlines_width:0] cnt_full = (nlines_width + 1)'(nlines);
    localparam logic [nlines_width:0] cnt_one  = (nlines_width + 1)'(1);

    logic [nlines_width:0]   count_q, count_d;
    logic [nlines_width-1:0] wr_line_q;
    logic                    line_v_q, full_q, single_q, end_q;

    always_comb begin
        count_d = count_q;
        err     = 1'b0;
        if (strm_rst) begin
            count_d = '0;
        end else if (wr && !free) begin
            count_d = count_q + 1'b1;
        end else if (free && !wr) begin
            if (count_q == '0) err = 1'b1;
            else               count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            wr_line_q <= '0;
            line_v_q  <= 1'b0;
            full_q    <= 1'b0;
            single_q  <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            line_v_q <= wr;
            // Flags decode the next count so they never lag the write that fills the stream.
            full_q   <= (count_d == cnt_full);
            single_q <= (count_d == cnt_one);
            if (strm_rst) begin
                wr_line_q <= '0;
                end_q     <= 1'b0;
            end else if (wr) begin
                wr_line_q <= wr_line_q + 1'b1;
                end_q     <= end_q | wr_end;
            end
        end
    end

    assign wr_line  = wr_line_q;
    assign line_v   = line_v_q;
    assign full     = full_q;
    assign single_v = single_q;
    assign end_flag = end_q;

endmodule

// File: rtl/l1_wr_port.sv
// L1 stream buffer fill port: one s1 register, BRAM line write issue and per-stream tracking.
module l1_wr_port
    import l1_pkg::*;
(
    input logic          clk,
    input logic          reset,
    l1_wr_port_if.slave  bus
);

    logic                    s1_v_q;
    logic [nstrms_width-1:0] s1_sid_q;
    cl_data_t                s1_data_q;
    logic                    s1_end_q;
    logic                    err_q;

    logic [nlines_width-1:0] wr_line [nstrms];
    strm_vec_t               wr_hit, line_v, full, single_v, end_flag, strm_err;

    logic       wr_v, wr_hs, drop, late_fill, s1_done, fill_r;
    line_addr_t wr_addr;
    cl_data_t   wr_data;

    // A stream reset on the held line's stream discards it silently, so it also blocks the write.
    assign drop      = s1_v_q & bus.i_strm_rst[s1_sid_q];
    assign late_fill = s1_v_q & end_flag[s1_sid_q] & ~drop;
    assign wr_v      = s1_v_q & ~full[s1_sid_q] & ~end_flag[s1_sid_q] & ~bus.i_strm_rst[s1_sid_q];
    assign wr_hs     = wr_v & bus.o_wr_r;
    assign s1_done   = wr_hs | drop | late_fill;
    assign fill_r    = ~s1_v_q | s1_done;
    assign wr_hit    = strm_vec_t'(wr_hs) << s1_sid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q    <= 1'b0;
            s1_sid_q  <= '0;
            s1_data_q <= '0;
            s1_end_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (bus.i_fill_v && fill_r) begin
                s1_v_q    <= 1'b1;
                s1_sid_q  <= bus.i_fill_sid;
                s1_data_q <= bus.i_fill_data;
                s1_end_q  <= bus.i_fill_end;
            end else if (s1_done) begin
                s1_v_q <= 1'b0;
            end
            err_q <= err_q | late_fill | (|strm_err);
        end
    end

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        if (wr_v) begin
            wr_addr.sid  = s1_sid_q;
            wr_addr.line = wr_line[s1_sid_q];
            wr_data      = s1_data_q;
        end
    end

    for (genvar s = 0; s < nstrms; s++) begin : g_strm
        l1_wr_strm_state u_state (
            .clk      (clk),
            .reset    (reset),
            .wr       (wr_hit[s]),
            .free     (bus.i_line_free[s]),
            .wr_end   (s1_end_q),
            .strm_rst (bus.i_strm_rst[s]),
            .wr_line  (wr_line[s]),
            .line_v   (line_v[s]),
            .full     (full[s]),
            .single_v (single_v[s]),
            .end_flag (end_flag[s]),
            .err      (strm_err[s])
        );
    end

    assign bus.i_fill_r   = fill_r;
    assign bus.o_wr_v     = wr_v;
    assign bus.o_wr_addr  = wr_addr;
    assign bus.o_wr_data  = wr_data;
    assign bus.o_line_v   = line_v;
    assign bus.o_full     = full;
    assign bus.o_single_v = single_v;
    assign bus.o_rst_end  = end_flag;
    assign bus.o_err      = err_q;

endmodule

// File: tb/tb_l1_wr_port.sv
// Directed bench for l1_wr_port: fills, full stall, simultaneous write/free, end, errors, reset.
module tb_l1_wr_port;
    import l1_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    l1_wr_port_if bus ();

    l1_wr_port dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cl_data_t pat(input int k);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(k);
        return {16{w}};
    endfunction

    // Presents one line and returns 1 ns after the edge that accepted it.
    task automatic fill(input int sid, input logic e, input int k);
        bit done;
        done = 1'b0;
        bus.i_fill_v    = 1'b1;
        bus.i_fill_sid  = nstrms_width'(sid);
        bus.i_fill_data = pat(k);
        bus.i_fill_end  = e;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.i_fill_r) done = 1'b1;
            tick();
        end
        bus.i_fill_v   = 1'b0;
        bus.i_fill_end = 1'b0;
        if (!done) chk("fill_timeout", 0, 1);
    endtask

    initial begin
        reset           = 1'b1;
        bus.i_fill_v    = 1'b0;
        bus.i_fill_sid  = '0;
        bus.i_fill_data = '0;
        bus.i_fill_end  = 1'b0;
        bus.o_wr_r      = 1'b1;
        bus.i_line_free = '0;
        bus.i_strm_rst  = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_fill_r",   bus.i_fill_r,   1);
        chk("rst_wr_v",     bus.o_wr_v,     0);
        chk("rst_full",     bus.o_full,     0);
        chk("rst_single",   bus.o_single_v, 0);
        chk("rst_end",      bus.o_rst_end,  0);
        chk("rst_line_v",   bus.o_line_v,   0);
        chk("rst_err",      bus.o_err,      0);

        // 1: four fills to stream 3
        fill(3, 0, 1);
        chk("t1_wr_v0",   bus.o_wr_v,    1);
        chk("t1_addr0",   bus.o_wr_addr, 12);
        chk("t1_data0",   bus.o_wr_data, pat(1));
        fill(3, 0, 2);
        chk("t1_addr1",   bus.o_wr_addr, 13);
        chk("t1_line_v1", bus.o_line_v[3], 1);
        fill(3, 0, 3);
        chk("t1_addr2",   bus.o_wr_addr, 14);
        fill(3, 0, 4);
        chk("t1_addr3",   bus.o_wr_addr, 15);
        chk("t1_full_n",  bus.o_full[3], 0);
        tick();
        chk("t1_full",    bus.o_full[3], 1);
        chk("t1_wr_v_n",  bus.o_wr_v, 0);
        chk("t1_line_v4", bus.o_line_v[3], 1);

        // 2: head-of-line blocking on full stream 3
        fill(3, 0, 5);
        chk("t2_blk_wr_v", bus.o_wr_v, 0);
        chk("t2_blk_r",    bus.i_fill_r, 0);
        bus.i_fill_v    = 1'b1;
        bus.i_fill_sid  = nstrms_width'(5);
        bus.i_fill_data = pat(6);
        tick();
        tick();
        chk("t2_hold_r",    bus.i_fill_r, 0);
        chk("t2_hold_wr_v", bus.o_wr_v, 0);
        bus.i_line_free[3] = 1'b1;
        tick();
        bus.i_line_free[3] = 1'b0;
        chk("t2_wrap_wr_v", bus.o_wr_v, 1);
        chk("t2_wrap_addr", bus.o_wr_addr, 12);
        chk("t2_wrap_data", bus.o_wr_data, pat(5));
        chk("t2_wrap_r",    bus.i_fill_r, 1);
        tick();
        bus.i_fill_v = 1'b0;
        chk("t2_s5_addr",   bus.o_wr_addr, 20);
        chk("t2_line_v3",   bus.o_line_v[3], 1);
        tick();
        chk("t2_full3",     bus.o_full[3], 1);
        chk("t2_single5",   bus.o_single_v[5], 1);
        chk("t2_line_v5",   bus.o_line_v[5], 1);

        // 3: simultaneous write and free on stream 7
        fill(7, 0, 7);
        tick();
        chk("t3_single_pre", bus.o_single_v[7], 1);
        fill(7, 0, 8);
        chk("t3_wr_v", bus.o_wr_v, 1);
        bus.i_line_free[7] = 1'b1;
        tick();
        bus.i_line_free[7] = 1'b0;
        chk("t3_single", bus.o_single_v[7], 1);
        chk("t3_line_v", bus.o_line_v[7], 1);
        chk("t3_full",   bus.o_full[7], 0);
        chk("t3_err",    bus.o_err, 0);

        // 4: end-of-stream, fill after end, stream reset
        fill(2, 1, 9);
        chk("t4_end_pre", bus.o_rst_end[2], 0);
        tick();
        chk("t4_end",     bus.o_rst_end[2], 1);
        chk("t4_err_n",   bus.o_err, 0);
        fill(2, 0, 10);
        chk("t4_late_wr_v", bus.o_wr_v, 0);
        tick();
        chk("t4_err",       bus.o_err, 1);
        chk("t4_no_line_v", bus.o_line_v[2], 0);
        bus.i_strm_rst[2] = 1'b1;
        tick();
        bus.i_strm_rst[2] = 1'b0;
        chk("t4_end_clr", bus.o_rst_end[2], 0);
        fill(2, 0, 11);
        chk("t4_wr_v",  bus.o_wr_v, 1);
        chk("t4_addr",  bus.o_wr_addr, 8);
        tick();

        // 5: free underflow, write backpressure
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_err_rst",  bus.o_err, 0);
        chk("t5_full_rst", bus.o_full[3], 0);
        bus.i_line_free[9] = 1'b1;
        tick();
        bus.i_line_free[9] = 1'b0;
        chk("t5_err",      bus.o_err, 1);
        chk("t5_single_n", bus.o_single_v[9], 0);
        bus.o_wr_r = 1'b0;
        fill(9, 0, 12);
        chk("t5_wr_v", bus.o_wr_v, 1);
        chk("t5_addr", bus.o_wr_addr, 36);
        chk("t5_data", bus.o_wr_data, pat(12));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_stall_wr_v",   bus.o_wr_v, 1);
            chk("t5_stall_addr",   bus.o_wr_addr, 36);
            chk("t5_stall_data",   bus.o_wr_data, pat(12));
            chk("t5_stall_line_v", bus.o_line_v[9], 0);
            chk("t5_stall_r",      bus.i_fill_r, 0);
        end
        bus.o_wr_r = 1'b1;
        tick();
        chk("t5_line_v",  bus.o_line_v[9], 1);
        chk("t5_single",  bus.o_single_v[9], 1);
        chk("t5_wr_v_n",  bus.o_wr_v, 0);
        tick();
        chk("t5_no_dup",  bus.o_line_v[9], 0);
        chk("t5_single2", bus.o_single_v[9], 1);

        // 6: reset while s1 holds a line
        bus.o_wr_r = 1'b0;
        fill(11, 1, 13);
        chk("t6_held", bus.o_wr_v, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.o_wr_r = 1'b1;
        chk("t6_wr_v",   bus.o_wr_v, 0);
        chk("t6_fill_r", bus.i_fill_r, 1);
        chk("t6_full",   bus.o_full, 0);
        chk("t6_single", bus.o_single_v, 0);
        chk("t6_end",    bus.o_rst_end, 0);
        chk("t6_line_v", bus.o_line_v, 0);
        chk("t6_err",    bus.o_err, 0);
        tick();
        chk("t6_idle_wr_v", bus.o_wr_v, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/l1_wr_port.md
Name: l1_wr_port

Overview:
- Fill side of the L1 stream buffer: the writer matching the L1 read ports.
- Accepts whole cachelines returned by L2, tagged with a stream id.
- Computes the L1 BRAM line address from a per-stream write pointer, issues one wide BRAM write per line, and tracks per-stream line occupancy.
- Line-valid, single-line and end-of-stream flags it exports are the i_single_v / i_rst_end inputs consumed by the read ports.

Parameters:
- nstrms, 64, number of streams
- nstrms_width, $clog2(nstrms), stream id width
- nlines, 4, L1 lines per stream (power of 2, >=2)
- nlines_width, $clog2(nlines), line index width
- cl_size, 8, words per cacheline
- word_width, 64, bits per word
- addr_width, nstrms_width+nlines_width, BRAM line address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_fill_v  in  1  L2 line valid
- i_fill_r  out  1  L2 line ready
- i_fill_sid  in  nstrms_width  target stream
- i_fill_data  in  cl_size*word_width  cacheline
- i_fill_end  in  1  this is the last line of the stream
- o_wr_v  out  1  BRAM write valid
- o_wr_r  in  1  BRAM write ready
- o_wr_addr  out  addr_width  {sid, wr_line}
- o_wr_data  out  cl_size*word_width  line data
- i_line_free  in  nstrms  read side retired one line of stream s (one bit per stream per cycle)
- i_strm_rst  in  nstrms  clear state of stream s
- o_line_v  out  nstrms  one-cycle pulse: line of stream s became valid
- o_full  out  nstrms  occupancy == nlines
- o_single_v  out  nstrms  occupancy == 1
- o_rst_end  out  nstrms  end line written for stream s
- o_err  out  1  sticky protocol error

Behaviour:
- Reset (synchronous, active-high):
  - All per-stream state cleared: wr_line = 0, count = 0, end = 0.
  - Pipeline register emptied; o_wr_v = 0, o_line_v = 0, o_err = 0.
  - o_full = 0, o_single_v = 0, o_rst_end = 0.
  - i_fill_r = 1 in the first cycle after reset deasserts.
- Stage s1: a single valid/ready register on the fill input.
  - i_fill_r = ~s1_v | (s1 handshake completes this cycle).
  - A line accepted in cycle N is presented as o_wr_v in cycle N+1 at the earliest.
- Issue condition: o_wr_v = s1_v & ~o_full[s1_sid] & ~end[s1_sid].
  - If the target stream is full, s1 holds and i_fill_r = 0; head-of-line blocking is intended.
  - If end[s1_sid] is already set, s1 is consumed without a write and o_err is set (fill after end).
- o_wr_addr = {s1_sid, wr_line[s1_sid]}; o_wr_data = s1 data. Both are zero when o_wr_v = 0 (power).
- On handshake o_wr_v & o_wr_r for stream s:
  - wr_line[s] increments, wrapping modulo nlines.
  - count[s] increments.
  - o_line_v[s] pulses in the next cycle.
  - If the s1 end bit was set, end[s] = 1.
- Per-cycle count update for stream s:
  - count += (write handshake to s) - i_line_free[s].
  - Simultaneous write and free: count is unchanged and o_line_v still pulses.
  - Free with count == 0 and no same-cycle write: ignored, o_err set.
- o_rst_end[s] = end[s], registered; stays high until i_strm_rst[s] or reset.
- i_strm_rst[s] clears wr_line, count and end for stream s.
  - If s1 holds a line for s, that line is dropped in the same cycle, with no write and no error.
  - Other streams are unaffected.
- o_full and o_single_v are registered decodes of count; they reflect an update one cycle after the handshake or free.
- o_err is sticky until reset.

Decomposition:
- Package l1_pkg holds:
  - the line address typedef {sid, line};
  - nlines / cl_size constants shared with the read ports;
  - the cacheline data typedef.
- Sub-module l1_wr_strm_state holds the per-stream wr_line, count and end registers with the inc/free/rst logic. It is generated nstrms times.
- The top level holds s1, the address mux and the sid decode.

Test Plan:
1. Reset, then fills sid=3 ×4, o_wr_r=1 -> o_wr_addr 3:0,3:1,3:2,3:3; o_line_v[3] pulses ×4; o_full[3]=1 after the 4th write.
2. Stream 3 full, fill sid=3 then sid=5 -> i_fill_r=0 and no write; single i_line_free[3] -> write to addr 3:0 (wrapped), then sid=5 writes 5:0.
3. count[7]=1, write handshake to stream 7 and i_line_free[7] in the same cycle -> count stays 1, o_single_v[7]=1, o_line_v[7] pulses.
4. Fill sid=2 with i_fill_end=1 -> o_rst_end[2]=1; further fill to sid=2 -> no write, o_err=1; i_strm_rst[2] -> o_rst_end[2]=0, next write to addr 2:0.
5. i_line_free[9] with count[9]=0 -> o_err=1, count stays 0; o_wr_r held 0 for 5 cycles -> o_wr_v, o_wr_addr and o_wr_data stable, no duplicate write.
6. Reset asserted while s1 holds a line -> next cycle o_wr_v=0, all flags 0, i_fill_r=1.
